scan_mux: RTL

//  Registered, parametrised N:1 channel selector; successor to the combinational 8:1 select/truth-table mux.

---
 rtl/scan_mux.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/scan_mux.sv
// -----------------------------------------------------------------------------
// scan_mux
//   Registered N:1 channel selector with four modes:
//     00 direct       : Y <= D[S], Ch <= S
//     01 scan         : walks channels 0..N_CH-1, DWELL cycles on each
//     10 truth-table  : Y <= tt[S] (tt is a writable N_CH-bit table)
//     11 hold         : Y/Ch/scan counters frozen (also used for unknown Mode)
//   Every output is registered. Y and Ch appear one cycle after the inputs
//   they were computed from are sampled.
//
// Ports
//   Clk      in   rising-edge clock
//   Rst_n    in   asynchronous active-low reset
//   Mode     in   [1:0] mode select
//   S        in   [SEL_W-1:0] external select
//   D        in   [N_CH*DATA_W-1:0] channel i at D[i*DATA_W +: DATA_W]
//   Tt_we    in   truth-table write strobe
//   Tt_data  in   [N_CH-1:0] new truth-table contents
//   Y        out  [DATA_W-1:0] registered output
//   Y_valid  out  Y reflects the current mode and inputs
//   Ch       out  [SEL_W-1:0] channel index that produced Y
//   Wrap     out  one-cycle pulse after scan wraps from channel N_CH-1 to 0
// -----------------------------------------------------------------------------
module scan_mux #(
    parameter int                     SEL_W   = 3,
    parameter int                     DATA_W  = 1,
    parameter int                     DWELL   = 4,
    parameter logic [(1<<SEL_W)-1:0]  TT_INIT = 8'h39
) (
    input  logic                            Clk,
    input  logic                            Rst_n,
    input  logic [1:0]                      Mode,
    input  logic [SEL_W-1:0]                S,
    input  logic [(1<<SEL_W)*DATA_W-1:0]    D,
    input  logic                            Tt_we,
    input  logic [(1<<SEL_W)-1:0]           Tt_data,
    output logic [DATA_W-1:0]               Y,
    output logic                            Y_valid,
    output logic [SEL_W-1:0]                Ch,
    output logic                            Wrap
);

    localparam int N_CH = 1 << SEL_W;
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(N_CH - 1);

    localparam logic [1:0] M_DIRECT = 2'b00;
    localparam logic [1:0] M_SCAN   = 2'b01;
    localparam logic [1:0] M_TT     = 2'b10;

    // state
    logic [N_CH-1:0]   tt;
    logic [SEL_W-1:0]  chan_cnt;
    logic [DW_W-1:0]   dwell_cnt;
    logic [1:0]        prev_mode;
    logic              started;   // set by the first edge after reset release

    // next-state
    logic [DATA_W-1:0] y_n;
    logic [SEL_W-1:0]  ch_n;
    logic              wrap_n;
    logic              valid_n;
    logic [SEL_W-1:0]  chan_n;
    logic [DW_W-1:0]   dwell_n;

    logic              mode_chg;
    logic              entering_scan;
    logic [SEL_W-1:0]  eff_chan;
    logic [DW_W-1:0]   eff_dwell;

    assign mode_chg      = (Mode != prev_mode);
    assign entering_scan = (Mode == M_SCAN) && mode_chg;

    // Entering scan restarts from channel 0 on the entry edge itself, so the
    // entry edge already presents channel 0 and counts as its first dwell
    // cycle; any count frozen by a previous hold is discarded.
    assign eff_chan  = entering_scan ? '0 : chan_cnt;
    assign eff_dwell = entering_scan ? '0 : dwell_cnt;

    // Next-state / output computation
    always_comb begin
        y_n     = Y;
        ch_n    = Ch;
        wrap_n  = 1'b0;
        chan_n  = chan_cnt;
        dwell_n = dwell_cnt;
        valid_n = started && !mode_chg;

        case (Mode)
            M_DIRECT: begin
                y_n     = D[S*DATA_W +: DATA_W];
                ch_n    = S;
                chan_n  = '0;
                dwell_n = '0;
            end
            M_TT: begin
                y_n     = '0;
                y_n[0]  = tt[S];
                ch_n    = S;
                chan_n  = '0;
                dwell_n = '0;
            end
            M_SCAN: begin
                y_n  = D[eff_chan*DATA_W +: DATA_W];
                ch_n = eff_chan;
                if (eff_dwell == DWELL_LAST) begin
                    dwell_n = '0;
                    chan_n  = eff_chan + 1'b1;   // natural wrap N_CH-1 -> 0
                    wrap_n  = (eff_chan == CH_LAST);
                end else begin
                    dwell_n = eff_dwell + 1'b1;
                    chan_n  = eff_chan;
                end
            end
            default: begin
                // hold and any unknown encoding: everything frozen
            end
        endcase
    end

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Y         <= '0;
            Y_valid   <= 1'b0;
            Ch        <= '0;
            Wrap      <= 1'b0;
            tt        <= TT_INIT;
            chan_cnt  <= '0;
            dwell_cnt <= '0;
            prev_mode <= M_DIRECT;
            started   <= 1'b0;
        end else begin
            Y         <= y_n;
            Y_valid   <= valid_n;
            Ch        <= ch_n;
            Wrap      <= wrap_n;
            chan_cnt  <= chan_n;
            dwell_cnt <= dwell_n;
            prev_mode <= Mode;
            started   <= 1'b1;
            if (Tt_we)
                tt <= Tt_data;
        end
    end

endmodule
